// File: rtl/recorder_ctrl.sv
// ---------------------------------------------------------------------------
// recorder_ctrl
//   Sample recorder/player between an AC97 codec and an external 64K x 8
//   sample memory. Records incoming samples on each (optionally decimated)
//   AC97 frame, replays them in a continuous loop, and passes the incoming
//   stream through to the codec output while idle or recording.
//
// Ports
//   clock          in   system clock, everything on the rising edge
//   reset          in   synchronous, active-high, highest priority
//   record         in   level, 1 = capture audio to memory
//   playback       in   level, 1 = replay stored audio
//   ready          in   one-cycle pulse per AC97 frame
//   decimate       in   1 = act on every 8th frame only
//   from_ac97_data in   [7:0] incoming sample, valid with ready
//   to_ac97_data   out  [7:0] outgoing sample (registered)
//   mem_addr       out  [15:0] sample memory address (registered)
//   mem_we         out  one-cycle write strobe
//   mem_din        out  [7:0] memory write data
//   mem_dout       in   [7:0] memory read data, 1 cycle after mem_addr
//   state          out  [1:0] IDLE=0, RECORD=1, PLAY=2
//   rec_len        out  [15:0] number of stored samples
//   full           out  memory full flag
// ---------------------------------------------------------------------------
module recorder_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        record,
    input  logic        playback,
    input  logic        ready,
    input  logic        decimate,
    input  logic [7:0]  from_ac97_data,
    output logic [7:0]  to_ac97_data,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic [1:0]  state,
    output logic [15:0] rec_len,
    output logic        full
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_RECORD = 2'd1;
    localparam logic [1:0]  ST_PLAY   = 2'd2;
    localparam logic [15:0] LEN_MAX   = 16'hFFFF;

    logic [1:0]  state_q,    state_d;
    logic [15:0] addr_q,     addr_d;
    logic [2:0]  phase_q,    phase_d;
    logic [15:0] rec_len_q,  rec_len_d;
    logic        full_q,     full_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q,   mem_we_d;
    logic [7:0]  mem_din_q,  mem_din_d;
    logic [7:0]  to_ac97_q,  to_ac97_d;
    // Captured write, strobed to memory one cycle after its frame so that a
    // reset in that cycle can still cancel it.
    logic        wr_pend_q,  wr_pend_d;
    logic [15:0] wr_addr_q,  wr_addr_d;
    logic [7:0]  wr_data_q,  wr_data_d;
    // Read pipeline: stage 1 = address on the bus, stage 2 = mem_dout valid.
    logic        rd_s1_q,    rd_s1_d;
    logic        rd_s2_q,    rd_s2_d;

    logic        qual_ready;
    logic        transition;
    logic [15:0] addr_inc;

    assign qual_ready = ready && (!decimate || (phase_q == 3'd0));
    assign transition = (state_d != state_q);
    assign addr_inc   = addr_q + 16'd1;

    // State register (and all other flops)
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            phase_q    <= '0;
            rec_len_q  <= '0;
            full_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            to_ac97_q  <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_s1_q    <= 1'b0;
            rd_s2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            rec_len_q  <= rec_len_d;
            full_q     <= full_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            to_ac97_q  <= to_ac97_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_s1_q    <= rd_s1_d;
            rd_s2_q    <= rd_s2_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (record)
                    state_d = ST_RECORD;
                else if (playback && (rec_len_q != 16'd0))
                    state_d = ST_PLAY;
            end
            ST_RECORD: begin
                if ((rec_len_q == LEN_MAX) || !record)
                    state_d = ST_IDLE;
            end
            ST_PLAY: begin
                if (!playback || record)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        addr_d     = addr_q;
        phase_d    = phase_q;
        rec_len_d  = rec_len_q;
        full_d     = full_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = 1'b0;
        wr_pend_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_s1_d    = 1'b0;
        rd_s2_d    = rd_s1_q;
        to_ac97_d  = to_ac97_q;

        if (transition) begin
            // A frame landing on a transition cycle is dropped entirely.
            if (state_d == ST_RECORD) begin
                addr_d    = '0;
                rec_len_d = '0;
                full_d    = 1'b0;
                phase_d   = '0;
            end else if (state_d == ST_PLAY) begin
                addr_d  = '0;
                phase_d = '0;
            end else if ((state_q == ST_RECORD) && (rec_len_q == LEN_MAX)) begin
                full_d = 1'b1;
            end
        end else if (ready && (state_q == ST_RECORD)) begin
            phase_d = phase_q + 3'd1;
            if (qual_ready) begin
                wr_pend_d = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = from_ac97_data;
                addr_d    = addr_inc;
                rec_len_d = rec_len_q + 16'd1;
            end
        end else if (ready && (state_q == ST_PLAY)) begin
            phase_d = phase_q + 3'd1;
            if (qual_ready) begin
                mem_addr_d = addr_q;
                rd_s1_d    = 1'b1;
                // Loop back to the first sample after the last stored one.
                addr_d     = (addr_inc == rec_len_q) ? 16'd0 : addr_inc;
            end
        end

        // A captured write always completes, even if RECORD was just left.
        if (wr_pend_q) begin
            mem_we_d   = 1'b1;
            mem_addr_d = wr_addr_q;
            mem_din_d  = wr_data_q;
        end

        if (ready && ((state_q == ST_IDLE) || (state_q == ST_RECORD)))
            to_ac97_d = from_ac97_data;
        else if (rd_s2_q)
            to_ac97_d = mem_dout;
    end

    // Outputs
    always_comb begin
        state        = state_q;
        rec_len      = rec_len_q;
        full         = full_q;
        mem_addr     = mem_addr_q;
        mem_we       = mem_we_q;
        mem_din      = mem_din_q;
        to_ac97_data = to_ac97_q;
    end

endmodule

// File: tb/tb_recorder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_recorder_ctrl
//   Scoreboard bench for recorder_ctrl. Stimulus tasks push expected memory
//   writes and expected to_ac97_data values (tagged with the cycle they must
//   be visible in) into queues; a monitor on the falling edge pops and
//   compares. Expectations come from a sample-list model: recorded samples
//   are frames whose index is a multiple of 8 (decimated) or all frames,
//   and playback output k is sample k modulo the recorded length.
// ---------------------------------------------------------------------------
module tb_recorder_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        record;
    logic        playback;
    logic        ready;
    logic        decimate;
    logic [7:0]  from_ac97_data;
    logic [7:0]  to_ac97_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [1:0]  state;
    logic [15:0] rec_len;
    logic        full;

    recorder_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .record         (record),
        .playback       (playback),
        .ready          (ready),
        .decimate       (decimate),
        .from_ac97_data (from_ac97_data),
        .to_ac97_data   (to_ac97_data),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .state          (state),
        .rec_len        (rec_len),
        .full           (full)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read sample memory
    logic [7:0] mem [0:65535];
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    typedef struct { int cyc; logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic [7:0] data; } out_t;
    wr_t  wr_q[$];
    out_t out_q[$];

    // Reference model: the list of recorded samples
    logic [7:0] rec_mem [0:65535];
    int         exp_len = 0;
    logic [7:0] fixed_q[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clock) begin
        wr_t  w;
        out_t o;
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
            w = wr_q.pop_front();
            check("write_strobe", {31'b0, mem_we}, 32'd1);
            check("write_addr", {16'b0, mem_addr}, {16'b0, w.addr});
            check("write_data", {24'b0, mem_din}, {24'b0, w.data});
            $display("write  cyc=%0d addr=%04h data=%02h", cyc, mem_addr, mem_din);
        end else if (mem_we) begin
            check("spurious_write", {31'b0, mem_we}, 32'd0);
        end
        if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
            o = out_q.pop_front();
            check("to_ac97_data", {24'b0, to_ac97_data}, {24'b0, o.data});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_out(input int c, input logic [7:0] v);
        out_t o;
        o.cyc  = c;
        o.data = v;
        out_q.push_back(o);
    endtask

    task automatic push_wr(input int c, input logic [15:0] a, input logic [7:0] v);
        wr_t w;
        w.cyc  = c;
        w.addr = a;
        w.data = v;
        wr_q.push_back(w);
    endtask

    task automatic pulse(input logic [7:0] d);
        from_ac97_data = d;
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    // Record n frames. drop_last lowers record together with the last frame;
    // ready_on_entry also issues a frame in the entry cycle (must be dropped).
    task automatic record_session(input int n, input bit dec, input int maxgap,
                                  input bit drop_last, input bit ready_on_entry);
        logic [7:0] d;
        bit         last;
        decimate = dec;
        record   = 1'b1;
        if (ready_on_entry) begin
            from_ac97_data = 8'hA5;
            ready = 1'b1;
        end
        step();
        ready   = 1'b0;
        exp_len = 0;
        for (int i = 0; i < n; i++) begin
            d    = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
            last = drop_last && (i == n - 1);
            if (last) record = 1'b0;
            else push_out(cyc + 1, d);
            if (!last && (!dec || (i % 8 == 0)) && exp_len < 65535) begin
                push_wr(cyc + 2, 16'(exp_len), d);
                rec_mem[exp_len] = d;
                exp_len++;
            end
            pulse(d);
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) step();
        end
        if (!drop_last) begin
            step();
            step();
            record = 1'b0;
        end
        step();
        step();
        check("rec_len_after_record", {16'b0, rec_len}, 32'(exp_len));
        check("state_after_record", {30'b0, state}, 32'd0);
        $display("record n=%0d dec=%0d rec_len=%0d exp=%0d", n, dec, rec_len, exp_len);
    endtask

    task automatic play_session(input int n, input bit dec, input int maxgap);
        int         q;
        logic [7:0] v;
        decimate = dec;
        playback = 1'b1;
        step();
        q = 0;
        v = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (!dec || (i % 8 == 0)) begin
                v = rec_mem[q % exp_len];
                q++;
            end
            push_out(cyc + 3, v);
            pulse(8'($urandom));
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) step();
        end
        repeat (4) step();
        playback = 1'b0;
        step();
        step();
        check("state_after_play", {30'b0, state}, 32'd0);
        $display("play   n=%0d dec=%0d last=%02h", n, dec, to_ac97_data);
    endtask

    task automatic idle_frames(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            push_out(cyc + 1, d);
            pulse(d);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq35 [0:7];
        seq35 = '{8'd5, 8'd17, 8'd9, 8'd21, 8'd66, 8'd75, 8'd43, 8'd12};
        reset = 1'b1; record = 1'b0; playback = 1'b0; ready = 1'b0;
        decimate = 1'b0; from_ac97_data = 8'h00;
        step();
        ready = 1'b1; from_ac97_data = 8'h3C;   // reset beats ready
        step();
        ready = 1'b0;
        check("reset_state", {30'b0, state}, 32'd0);
        check("reset_rec_len", {16'b0, rec_len}, 32'd0);
        check("reset_full", {31'b0, full}, 32'd0);
        check("reset_mem_we", {31'b0, mem_we}, 32'd0);
        check("reset_mem_addr", {16'b0, mem_addr}, 32'd0);
        check("reset_mem_din", {24'b0, mem_din}, 32'd0);
        check("reset_to_ac97", {24'b0, to_ac97_data}, 32'd0);
        reset = 1'b0;
        step();

        // Fixed record then loop playback
        for (int i = 0; i < 8; i++) fixed_q.push_back(seq35[i]);
        record_session(8, 1'b0, 2, 1'b0, 1'b0);
        play_session(10, 1'b0, 2);

        // Decimated record of 0..15: only 0 and 8 stored
        for (int i = 0; i < 16; i++) fixed_q.push_back(8'(i));
        record_session(16, 1'b1, 1, 1'b0, 1'b0);
        check("decimated_rec_len", {16'b0, rec_len}, 32'd2);

        // Record wins over playback; empty memory never plays
        record = 1'b1; playback = 1'b1;
        step();
        check("record_wins", {30'b0, state}, 32'd1);
        record = 1'b0; playback = 1'b0;
        exp_len = 0;
        step();
        step();
        playback = 1'b1;
        repeat (3) step();
        check("play_empty_stays_idle", {30'b0, state}, 32'd0);
        playback = 1'b0;
        step();

        // Frame on the entry cycle is ignored (no write, phase untouched)
        record_session(17, 1'b1, 1, 1'b0, 1'b1);
        idle_frames(3);

        // Randomized record/play rounds
        for (int r = 0; r < 6; r++) begin
            record_session($urandom_range(1, 40), 1'($urandom), 3, 1'b0, 1'b0);
            idle_frames($urandom_range(0, 3));
            play_session($urandom_range(1, 30), 1'($urandom), 2);
        end

        // Reset one cycle after a qualifying frame in RECORD: no strobe
        decimate = 1'b0;
        record = 1'b1;
        step();
        pulse(8'h77);
        reset = 1'b1;
        record = 1'b0;
        step();
        reset = 1'b0;
        exp_len = 0;
        step();
        step();
        check("abort_rec_len", {16'b0, rec_len}, 32'd0);
        check("abort_state", {30'b0, state}, 32'd0);
        check("abort_to_ac97", {24'b0, to_ac97_data}, 32'd0);

        // Fill memory: last write at FFFE, then full and back to IDLE
        record_session(65536, 1'b0, 0, 1'b1, 1'b0);
        check("full_flag", {31'b0, full}, 32'd1);
        check("full_rec_len", {16'b0, rec_len}, 32'h0000FFFF);
        play_session(3, 1'b0, 1);

        repeat (4) step();
        check("write_queue_drained", 32'(wr_q.size()), 32'd0);
        check("out_queue_drained", 32'(out_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
